i2c_pkt_master: RTL

//  Parametrised I2C write-packet master: on a trigger, sends START, address byte, NUM_BYTES payload bytes, then STOP.

---
 rtl/i2c_pkt_pkg.sv | 13 +
 rtl/i2c_qtick_gen.sv | 46 ++++
 rtl/i2c_pkt_master.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkt_pkg.sv
// Shared types and constants for the I2C write-packet master.
// Optional retry support in i2c_pkt_master is enabled with I2C_PKT_RETRY_EN.
package i2c_pkt_pkg;

    typedef enum logic [2:0] {IDLE, START, WBIT, RACK, STOP, DONE} i2c_pkt_state_t;

    localparam logic R_W_WRITE = 1'b0;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr);
        return {addr, R_W_WRITE};
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// SCL quarter-phase generator: qt pulses every CLK_DIV clocks while enabled,
// q counts quarters 0..3; both are held at zero while disabled.
module i2c_qtick_gen #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic       qt_o,
    output logic [1:0] q_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       q_q, q_d;

    assign qt_o = en_i && (cnt_q == CNT_MAX);
    assign q_o  = q_q;

    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (!en_i) begin
            cnt_d = '0;
            q_d   = '0;
        end else if (qt_o) begin
            cnt_d = '0;
            q_d   = q_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            q_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

endmodule

// File: rtl/i2c_pkt_master.sv
// I2C write-packet master: START, address byte, NUM_BYTES payload bytes, STOP, with ACK checks.
// Define I2C_PKT_RETRY_EN to restart a NACKed packet up to MAX_RETRY extra times.
module i2c_pkt_master
    import i2c_pkt_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 5,
    parameter int unsigned CLK_DIV   = 250,
    parameter logic [6:0]  SLV_ADDR  = 7'h42,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   send_trigger,
    input  logic [NUM_BYTES*8-1:0] payload,
    output logic                   busy,
    output logic                   done,
    output logic                   nack_err,
    output logic                   SCL,
    inout  wire                    SDA
);

`ifdef I2C_PKT_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int unsigned BIDX_W  = $clog2(NUM_BYTES + 1);
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [BIDX_W-1:0]  LAST_BIDX = BIDX_W'(NUM_BYTES);
    localparam logic [RETRY_W-1:0] MAX_R     = RETRY_W'(MAX_RETRY);
    localparam logic [7:0]         ADDR_BYTE = addr_byte(SLV_ADDR);

    i2c_pkt_state_t state_q, state_d;
    logic [NUM_BYTES*8-1:0] payload_q, payload_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [BIDX_W-1:0]  bidx_q, bidx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               err_q, err_d;
    logic               ack_q, ack_d;
    logic               scl_q, scl_d;
    logic               sda_oe_q, sda_oe_d;
    logic               sda_meta_q, sda_sync_q;

    logic       qt;
    logic [1:0] q;
    logic       q_end;

    i2c_qtick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_qtick (
        .clk_i (clk),
        .rst_ni(reset),
        .en_i  (busy),
        .qt_o  (qt),
        .q_o   (q)
    );

    assign q_end    = qt && (q == 2'd3);
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign nack_err = done && err_q;
    assign SCL      = scl_q;
    assign SDA      = sda_oe_q ? 1'b0 : 1'bz;

    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        bidx_d    = bidx_q;
        retry_d   = retry_q;
        err_d     = err_q;
        ack_d     = ack_q;
        scl_d     = 1'b1;
        sda_oe_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (send_trigger) begin
                    state_d   = START;
                    payload_d = payload;
                    shift_d   = ADDR_BYTE;
                    bit_cnt_d = '0;
                    bidx_d    = '0;
                    retry_d   = '0;
                    err_d     = 1'b0;
                end
            end
            START: begin
                sda_oe_d = q[1];
                if (q_end) state_d = WBIT;
            end
            WBIT: begin
                scl_d    = q[1];
                sda_oe_d = ~shift_q[7];
                if (q_end) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RACK;
                end
            end
            RACK: begin
                scl_d = q[1];
                if (qt && (q == 2'd2)) ack_d = sda_sync_q;
                if (q_end) begin
                    if (ack_q) begin
                        err_d   = 1'b1;
                        state_d = STOP;
                    end else if (bidx_q == LAST_BIDX) begin
                        state_d = STOP;
                    end else begin
                        // bidx counts the address as byte 0, so payload byte bidx is next
                        shift_d = payload_q[{bidx_q, 3'b000} +: 8];
                        bidx_d  = bidx_q + 1'b1;
                        state_d = WBIT;
                    end
                end
            end
            STOP: begin
                scl_d    = (q != 2'd0);
                sda_oe_d = ~q[1];
                if (q_end) begin
                    if (RETRY_EN && err_q && (retry_q < MAX_R)) begin
                        retry_d   = retry_q + 1'b1;
                        err_d     = 1'b0;
                        shift_d   = ADDR_BYTE;
                        bit_cnt_d = '0;
                        bidx_d    = '0;
                        state_d   = START;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            payload_q  <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            bidx_q     <= '0;
            retry_q    <= '0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            payload_q  <= payload_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            bidx_q     <= bidx_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            sda_meta_q <= SDA;
            sda_sync_q <= sda_meta_q;
        end
    end

endmodule
